// File: rtl/nmea_frame_checker_pkg.sv
// ----------------------------------------------------------------------------
// roversPackage
// Shared types and helpers for the NMEA sentence checker:
//   nmea_err_t    - reason code reported with frame_err
//   nmea_state_t  - sentence parser states
//   NMEA_START    - '$', opens a sentence
//   NMEA_CKSEP    - '*', separates payload from the two checksum digits
//   hex_decode()  - ASCII hex digit to {valid, nibble}
// ----------------------------------------------------------------------------
package roversPackage;

   typedef enum logic [1:0] {
      NONE      = 2'd0,
      BAD_CKSUM = 2'd1,
      OVERFLOW  = 2'd2,
      BAD_CHAR  = 2'd3
   } nmea_err_t;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      PAYLOAD = 3'd1,
      CK_HI   = 3'd2,
      CK_LO   = 3'd3,
      CHECK   = 3'd4,
      DRAIN   = 3'd5
   } nmea_state_t;

   localparam logic [7:0] NMEA_START = 8'h24;
   localparam logic [7:0] NMEA_CKSEP = 8'h2A;

   // Returns {1'b1, value} for 0-9, A-F, a-f and 5'b0 for anything else.
   // Letters share the same low nibble in both cases (0x41/0x61 -> 1),
   // so adding 9 to the low nibble yields 10..15.
   function automatic logic [4:0] hex_decode(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39) begin
         r = {1'b1, c[3:0]};
      end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
         r = {1'b1, c[3:0] + 4'd9};
      end
      return r;
   endfunction

endpackage

// File: rtl/nmea_sentence_buf.sv
// ----------------------------------------------------------------------------
// nmea_sentence_buf
// Simple dual-port payload buffer, DEPTH x 8, one write port and one read
// port with a registered read (maps onto block RAM with output register).
// Ports:
//   clk      - clock
//   srst     - synchronous active-high reset of the read register only
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe; rd_data holds its value while low
//   rd_addr  - read address
//   rd_data  - registered read data
// ----------------------------------------------------------------------------
module nmea_sentence_buf #(
   parameter int DEPTH  = 80,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // The read register is the downstream data output, so it only moves
   // when a new byte is requested; that is what keeps data stable in stalls.
   always_ff @(posedge clk) begin
      if (srst) begin
         rd_data <= 8'h00;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/nmea_frame_checker.sv
// ----------------------------------------------------------------------------
// nmea_frame_checker
// Parses NMEA-0183 sentences ("$payload*HH") from a UART byte stream,
// verifies the XOR checksum and forwards accepted payloads over a
// valid/ready stream.
// Ports:
//   sclk, rst           - clock, synchronous active-high reset
//   rx_data, rx_valid   - incoming bytes, one-cycle strobe, no back-pressure
//   out_data, out_valid, out_ready, out_last - payload stream out
//   frame_ok, frame_len - pulse on accepted sentence; length held
//   frame_err, err_code - pulse on rejected sentence; reason held
//   drop_cnt            - saturating count of bytes ignored while busy
// ----------------------------------------------------------------------------
module nmea_frame_checker
   import roversPackage::*;
#(
   parameter int MAX_PAYLOAD = 80,
   parameter int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             frame_ok,
   output logic [LEN_W-1:0] frame_len,
   output logic             frame_err,
   output nmea_err_t        err_code,
   output logic [7:0]       drop_cnt
);

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PAYLOAD);

   nmea_state_t      state_reg, state_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic [7:0]       xor_reg, xor_next;
   logic [3:0]       ck_hi_reg, ck_hi_next;
   logic [LEN_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic             out_valid_reg, out_valid_next;
   logic             out_last_reg, out_last_next;
   logic             frame_ok_reg, frame_ok_next;
   logic             frame_err_reg, frame_err_next;
   logic [LEN_W-1:0] frame_len_reg, frame_len_next;
   nmea_err_t        err_code_reg, err_code_next;
   logic [7:0]       drop_cnt_reg, drop_cnt_next;

   logic             wr_en;
   logic             rd_en;
   logic [LEN_W-1:0] rd_addr;
   logic [4:0]       hex;
   logic             printable;

   nmea_sentence_buf #(
      .DEPTH  (MAX_PAYLOAD),
      .ADDR_W (LEN_W)
   ) u_buf (
      .clk     (sclk),
      .srst    (rst),
      .wr_en   (wr_en),
      .wr_addr (len_reg),
      .wr_data (rx_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (out_data)
   );

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_reg     <= HUNT;
         len_reg       <= '0;
         xor_reg       <= 8'h00;
         ck_hi_reg     <= 4'h0;
         rd_ptr_reg    <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         frame_ok_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         frame_len_reg <= '0;
         err_code_reg  <= NONE;
         drop_cnt_reg  <= 8'h00;
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         xor_reg       <= xor_next;
         ck_hi_reg     <= ck_hi_next;
         rd_ptr_reg    <= rd_ptr_next;
         out_valid_reg <= out_valid_next;
         out_last_reg  <= out_last_next;
         frame_ok_reg  <= frame_ok_next;
         frame_err_reg <= frame_err_next;
         frame_len_reg <= frame_len_next;
         err_code_reg  <= err_code_next;
         drop_cnt_reg  <= drop_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      xor_next       = xor_reg;
      ck_hi_next     = ck_hi_reg;
      rd_ptr_next    = rd_ptr_reg;
      out_valid_next = out_valid_reg;
      out_last_next  = out_last_reg;
      frame_ok_next  = 1'b0;
      frame_err_next = 1'b0;
      frame_len_next = frame_len_reg;
      err_code_next  = err_code_reg;
      drop_cnt_next  = drop_cnt_reg;
      wr_en          = 1'b0;
      rd_en          = 1'b0;
      rd_addr        = rd_ptr_reg;
      hex            = hex_decode(rx_data);
      printable      = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

      if (rx_valid && (state_reg == CHECK || state_reg == DRAIN) && drop_cnt_reg != 8'hFF) begin
         drop_cnt_next = drop_cnt_reg + 8'd1;
      end

      case (state_reg)
         HUNT: begin
            if (rx_valid && rx_data == NMEA_START) begin
               len_next   = '0;
               xor_next   = 8'h00;
               state_next = PAYLOAD;
            end
         end

         PAYLOAD: begin
            if (rx_valid) begin
               if (rx_data == NMEA_START) begin
                  len_next = '0;
                  xor_next = 8'h00;
               end else if (rx_data == NMEA_CKSEP) begin
                  state_next = CK_HI;
               end else if (!printable) begin
                  frame_err_next = 1'b1;
                  err_code_next  = BAD_CHAR;
                  state_next     = HUNT;
               end else if (len_reg == LEN_MAX) begin
                  frame_err_next = 1'b1;
                  err_code_next  = OVERFLOW;
                  state_next     = HUNT;
               end else begin
                  wr_en    = 1'b1;
                  xor_next = xor_reg ^ rx_data;
                  len_next = len_reg + LEN_ONE;
               end
            end
         end

         CK_HI: begin
            if (rx_valid) begin
               if (rx_data == NMEA_START) begin
                  len_next   = '0;
                  xor_next   = 8'h00;
                  state_next = PAYLOAD;
               end else if (hex[4]) begin
                  ck_hi_next = hex[3:0];
                  state_next = CK_LO;
               end else begin
                  frame_err_next = 1'b1;
                  err_code_next  = BAD_CHAR;
                  state_next     = HUNT;
               end
            end
         end

         CK_LO: begin
            if (rx_valid) begin
               if (rx_data == NMEA_START) begin
                  len_next   = '0;
                  xor_next   = 8'h00;
                  state_next = PAYLOAD;
               end else if (hex[4]) begin
                  // The verdict is resolved against the final digit here so
                  // that the registered frame_ok/frame_err are already high
                  // throughout the CHECK cycle that follows.
                  state_next = CHECK;
                  if ({ck_hi_reg, hex[3:0]} == xor_reg) begin
                     frame_ok_next  = 1'b1;
                     frame_len_next = len_reg;
                  end else begin
                     frame_err_next = 1'b1;
                     err_code_next  = BAD_CKSUM;
                  end
               end else begin
                  frame_err_next = 1'b1;
                  err_code_next  = BAD_CHAR;
                  state_next     = HUNT;
               end
            end
         end

         CHECK: begin
            // frame_ok_reg is the verdict for this sentence; prefetch byte 0
            // so it is presented on the very next cycle.
            if (frame_ok_reg && len_reg != '0) begin
               rd_en          = 1'b1;
               rd_addr        = '0;
               rd_ptr_next    = LEN_ONE;
               out_valid_next = 1'b1;
               out_last_next  = (len_reg == LEN_ONE);
               state_next     = DRAIN;
            end else begin
               state_next = HUNT;
            end
         end

         DRAIN: begin
            if (out_valid_reg && out_ready) begin
               if (out_last_reg) begin
                  out_valid_next = 1'b0;
                  out_last_next  = 1'b0;
                  state_next     = HUNT;
               end else begin
                  rd_en         = 1'b1;
                  rd_ptr_next   = rd_ptr_reg + LEN_ONE;
                  out_last_next = ((rd_ptr_reg + LEN_ONE) == len_reg);
               end
            end
         end

         default: begin
            state_next = HUNT;
         end
      endcase
   end

   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;
   assign frame_ok  = frame_ok_reg;
   assign frame_err = frame_err_reg;
   assign frame_len = frame_len_reg;
   assign err_code  = err_code_reg;
   assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_nmea_frame_checker.sv
// ----------------------------------------------------------------------------
// tb_nmea_frame_checker
// Directed and randomized sentences checked against expectations built from
// the sentence text itself (payload, XOR of payload, where the sentence
// breaks the rules).
// ----------------------------------------------------------------------------
module tb_nmea_frame_checker;
   import roversPackage::*;

   localparam int MAX = 80;
   localparam int LW  = $clog2(MAX + 1);

   logic          sclk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_last;
   logic          frame_ok;
   logic [LW-1:0] frame_len;
   logic          frame_err;
   nmea_err_t     err_code;
   logic [7:0]    drop_cnt;

   int checks = 0;
   int errors = 0;

   // event counters kept by the monitor
   int ok_seen = 0;
   int err_seen = 0;
   int xfer_seen = 0;
   int stab_bad = 0;

   // expectations
   int          exp_ok = 0;
   int          exp_err = 0;
   int          exp_xfer = 0;
   int          exp_drop = 0;
   int          exp_len_held = 0;
   nmea_err_t   exp_code_held = NONE;
   int          exp_kind = 0;
   nmea_err_t   exp_code = NONE;
   logic [7:0]  tx_q[$];
   logic [7:0]  exp_pay[$];
   int          frame_no = 0;

   always #5 sclk = ~sclk;

   nmea_frame_checker #(.MAX_PAYLOAD(MAX)) dut (
      .sclk      (sclk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .frame_ok  (frame_ok),
      .frame_len (frame_len),
      .frame_err (frame_err),
      .err_code  (err_code),
      .drop_cnt  (drop_cnt)
   );

   // Monitor: counts pulses/transfers and flags any change while stalled.
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = 8'h00;
   logic       stall_last = 1'b0;
   always @(negedge sclk) begin
      if (rst) begin
         stall_prev <= 1'b0;
      end else begin
         if (frame_ok === 1'b1) ok_seen <= ok_seen + 1;
         if (frame_err === 1'b1) err_seen <= err_seen + 1;
         if (out_valid === 1'b1 && out_ready === 1'b1) xfer_seen <= xfer_seen + 1;
         if (stall_prev && (out_valid !== 1'b1 || out_data !== stall_data || out_last !== stall_last))
            stab_bad <= stab_bad + 1;
         stall_prev <= (out_valid === 1'b1) && (out_ready === 1'b0);
         stall_data <= out_data;
         stall_last <= out_last;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_drop      = 0;
      exp_len_held  = 0;
      exp_code_held = NONE;
   endtask

   task automatic load(input string s);
      tx_q.delete();
      for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
   endtask

   task automatic expect_ok(input string p);
      exp_kind = 0;
      exp_pay.delete();
      for (int i = 0; i < p.len(); i++) exp_pay.push_back(p[i]);
   endtask

   task automatic expect_err(input nmea_err_t c);
      exp_kind = 1;
      exp_code = c;
      exp_pay.delete();
   endtask

   function automatic logic [7:0] hexch(input logic [3:0] v);
      if (v < 4'd10) return 8'h30 + {4'h0, v};
      return (($urandom_range(0, 1) == 1) ? 8'h41 : 8'h61) + {4'h0, v} - 8'd10;
   endfunction

   // Random sentence: printable payload, then either a correct checksum,
   // a corrupted checksum, a control/high byte, or too many bytes.
   task automatic build_random();
      int         n;
      int         mode;
      int         p;
      logic [7:0] c;
      logic [7:0] x;
      logic [7:0] ck;
      logic [7:0] bad;
      logic [7:0] pay[$];
      n    = $urandom_range(0, MAX + 2);
      mode = $urandom_range(0, 3);
      x    = 8'h00;
      for (int i = 0; i < n; i++) begin
         c = 8'($urandom_range(32, 126));
         while (c == 8'h24 || c == 8'h2A) c = 8'($urandom_range(32, 126));
         pay.push_back(c);
         x = x ^ c;
      end
      tx_q.delete();
      tx_q.push_back(8'h24);
      if (mode == 3) begin
         p = $urandom_range(0, (n < MAX) ? n : MAX);
         for (int i = 0; i < p; i++) tx_q.push_back(pay[i]);
         bad = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 255));
         tx_q.push_back(bad);
         expect_err(BAD_CHAR);
      end else if (n > MAX) begin
         for (int i = 0; i <= MAX; i++) tx_q.push_back(pay[i]);
         expect_err(OVERFLOW);
      end else begin
         for (int i = 0; i < n; i++) tx_q.push_back(pay[i]);
         tx_q.push_back(8'h2A);
         ck = (mode == 2) ? (x ^ 8'($urandom_range(1, 255))) : x;
         tx_q.push_back(hexch(ck[7:4]));
         tx_q.push_back(hexch(ck[3:0]));
         if (mode == 2) begin
            expect_err(BAD_CKSUM);
         end else begin
            exp_kind = 0;
            exp_pay  = pay;
         end
      end
   endtask

   // mode: 0 ready held high, 1 random ready, 2 ten stalls then toggle,
   // 3 long stall. inject: bytes pushed on rx while draining.
   task automatic drain(input int mode, input int inject);
      int   i;
      int   cyc;
      int   left;
      int   n;
      logic r;
      n = exp_pay.size();
      i = 0;
      cyc = 0;
      left = inject;
      tick();
      chk("first_valid_n2", 32'(out_valid), 1);
      while (i < n && cyc < 3000) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            2:       r = (cyc < 10) ? 1'b0 : 1'(cyc % 2);
            default: r = (cyc >= 280);
         endcase
         out_ready = r;
         chk("drain_valid", 32'(out_valid), 1);
         if (out_valid === 1'b1) begin
            chk("out_data", 32'(out_data), 32'(exp_pay[i]));
            chk("out_last", 32'(out_last), 32'(i == n - 1));
            if (left > 0) begin
               rx_data  = 8'($urandom);
               rx_valid = 1'b1;
               left--;
               if (exp_drop < 255) exp_drop++;
            end
            if (r) i++;
         end
         cyc++;
         tick();
         rx_valid = 1'b0;
      end
      chk("drain_done", i, n);
      if (mode == 0) chk("no_bubble", cyc, n);
      chk("valid_after_last", 32'(out_valid), 0);
      exp_xfer += n;
   endtask

   task automatic run_frame(input int mode, input int inject);
      int n;
      n = exp_pay.size();
      out_ready = (mode == 0 || mode == 1);
      foreach (tx_q[k]) send(tx_q[k]);
      frame_no++;
      if (exp_kind == 0) begin
         chk("frame_ok", 32'(frame_ok), 1);
         chk("frame_err_quiet", 32'(frame_err), 0);
         chk("frame_len", 32'(frame_len), n);
         chk("err_code_held", 32'(err_code), 32'(exp_code_held));
         exp_ok++;
         exp_len_held = n;
         $display("frame %0d: %0d bytes sent, expect ok len=%0d", frame_no, tx_q.size(), n);
      end else begin
         chk("frame_err", 32'(frame_err), 1);
         chk("frame_ok_quiet", 32'(frame_ok), 0);
         chk("err_code", 32'(err_code), 32'(exp_code));
         chk("frame_len_held", 32'(frame_len), exp_len_held);
         exp_err++;
         exp_code_held = exp_code;
         $display("frame %0d: %0d bytes sent, expect reject code=%0d", frame_no, tx_q.size(), exp_code);
      end
      if (exp_kind == 0 && n > 0) begin
         drain(mode, inject);
      end else begin
         tick();
         chk("idle_valid", 32'(out_valid), 0);
      end
      tick();
      tick();
      chk("ok_count", ok_seen, exp_ok);
      chk("err_count", err_seen, exp_err);
      chk("xfer_count", xfer_seen, exp_xfer);
      chk("drop_cnt", 32'(drop_cnt), exp_drop);
      chk("stall_stable", stab_bad, 0);
   endtask

   initial begin
      tick();
      do_reset();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_frame_ok", 32'(frame_ok), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_frame_len", 32'(frame_len), 0);
      chk("rst_err_code", 32'(err_code), 32'(NONE));
      chk("rst_drop_cnt", 32'(drop_cnt), 0);
      chk("rst_out_data", 32'(out_data), 0);

      load("$AB*03"); expect_ok("AB"); run_frame(0, 0);

      // trailing CR/LF land in HUNT and are ignored
      send(8'h0D); send(8'h0A); tick();
      chk("crlf_ok_count", ok_seen, exp_ok);
      chk("crlf_err_count", err_seen, exp_err);
      chk("crlf_drop", 32'(drop_cnt), exp_drop);

      load("$AB*04"); expect_err(BAD_CKSUM); run_frame(0, 0);

      tx_q.delete();
      tx_q.push_back(8'h24);
      repeat (MAX + 1) tx_q.push_back(8'h41);
      expect_err(OVERFLOW); run_frame(0, 0);
      load("$A*41"); expect_ok("A"); run_frame(0, 0);

      do_reset();
      load("$AB*03"); expect_ok("AB"); run_frame(2, 3);

      load("$AB$CD*07"); expect_ok("CD"); run_frame(1, 0);
      tx_q.delete();
      tx_q.push_back(8'h24); tx_q.push_back(8'h41); tx_q.push_back(8'h01);
      expect_err(BAD_CHAR); run_frame(0, 0);
      load("$AB*0g"); expect_err(BAD_CHAR); run_frame(0, 0);

      load("$*00"); expect_ok(""); run_frame(0, 0);

      // exactly MAX bytes: an even count of identical bytes XORs to 0
      tx_q.delete();
      exp_pay.delete();
      tx_q.push_back(8'h24);
      repeat (MAX) tx_q.push_back(8'h5A);
      tx_q.push_back(8'h2A); tx_q.push_back(8'h30); tx_q.push_back(8'h30);
      exp_kind = 0;
      repeat (MAX) exp_pay.push_back(8'h5A);
      run_frame(1, 0);

      for (int k = 0; k < 30; k++) begin
         build_random();
         run_frame($urandom_range(0, 1), $urandom_range(0, 3));
      end

      // drop counter saturation
      load("$AB*03"); expect_ok("AB"); run_frame(3, 270);

      // reset in the middle of a drain
      load("$AB*03");
      out_ready = 1'b0;
      foreach (tx_q[k]) send(tx_q[k]);
      chk("rstd_frame_ok", 32'(frame_ok), 1);
      exp_ok++;
      tick();
      chk("rstd_valid_before", 32'(out_valid), 1);
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      chk("rstd_drop_before", 32'(drop_cnt), (exp_drop < 255) ? exp_drop + 1 : 255);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_drop = 0;
      exp_len_held = 0;
      exp_code_held = NONE;
      chk("rstd_valid_after", 32'(out_valid), 0);
      chk("rstd_drop_after", 32'(drop_cnt), 0);
      chk("rstd_frame_err", 32'(frame_err), 0);
      tick();
      tick();
      chk("rstd_err_count", err_seen, exp_err);
      chk("rstd_xfer_count", xfer_seen, exp_xfer);
      load("$A*41"); expect_ok("A"); run_frame(0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nmea_frame_checker.md
NMEA_FRAME_CHECKER -- requirements
Module: nmea_frame_checker

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 80, the maximum number of payload bytes between '$' and '*'.
REQ-002 SHALL have parameter LEN_W, default $clog2(MAX_PAYLOAD+1), the width of the length output.
REQ-003 SHALL have port sclk, input, 1, the single system clock; all logic is in this domain.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port rx_data, input, 8, the byte from the GPS UART receiver.
REQ-006 SHALL have port rx_valid, input, 1, a one-cycle strobe meaning rx_data is valid; there is no back-pressure.
REQ-007 SHALL have port out_data, output, 8, the validated payload byte.
REQ-008 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-009 SHALL have port out_ready, input, 1, the consumer accept; a byte transfers when out_valid and out_ready are both high.
REQ-010 SHALL have port out_last, output, 1, high with the final payload byte.
REQ-011 SHALL have port frame_ok, output, 1, a one-cycle pulse when a sentence passes its checksum.
REQ-012 SHALL have port frame_len, output, LEN_W, the payload length; it is held from frame_ok until the next frame_ok.
REQ-013 SHALL have port frame_err, output, 1, a one-cycle pulse when a sentence is rejected.
REQ-014 SHALL have port err_code, output, 2, the reason for the last error (nmea_err_t), held until the next frame_err.
REQ-015 SHALL have port drop_cnt, output, 8, a saturating count of bytes dropped while draining.

Function
REQ-016 SHALL implement the states HUNT, PAYLOAD, CK_HI, CK_LO, CHECK and DRAIN.
REQ-017 In HUNT, SHALL ignore every byte except '$' (0x24); '$' clears the running XOR and the length, then moves to PAYLOAD.
REQ-018 In PAYLOAD, a byte from 0x20 to 0x7E other than '*' or '$' SHALL be written to the buffer at index len, XORed into the running checksum, and len incremented.
REQ-019 In PAYLOAD, '*' (0x2A) SHALL move to CK_HI without entering the checksum.
REQ-020 In PAYLOAD, CK_HI or CK_LO, '$' SHALL restart the sentence (as in HUNT) with no frame_err.
REQ-021 In PAYLOAD, a byte outside 0x20-0x7E SHALL cause frame_err with code BAD_CHAR and a return to HUNT.
REQ-022 A printable byte arriving in PAYLOAD when len == MAX_PAYLOAD SHALL cause frame_err with code OVERFLOW and a return to HUNT.
REQ-023 CK_HI and CK_LO SHALL each accept one hex digit (0-9, A-F, a-f) as the received checksum nibble; any other byte SHALL cause frame_err BAD_CHAR and a return to HUNT.
REQ-024 If the CK_LO digit is accepted in cycle N, SHALL spend cycle N+1 in CHECK and compare the received checksum with the running XOR there.
REQ-025 On a checksum mismatch, SHALL pulse frame_err (code BAD_CKSUM) in cycle N+1 and return to HUNT.
REQ-026 On a checksum match, SHALL pulse frame_ok in cycle N+1, load frame_len, and enter DRAIN.
REQ-027 On a match with len == 0, SHALL pulse frame_ok with frame_len = 0, skip DRAIN and return to HUNT.
REQ-028 In DRAIN, buffer reads SHALL be registered, with out_valid first high in cycle N+2 carrying payload byte 0.
REQ-029 In DRAIN, SHALL advance one byte per out_valid&&out_ready with no bubbles while out_ready is held high.
REQ-030 While out_valid is high and out_ready is low, out_data and out_last SHALL be held stable.
REQ-031 SHALL return to HUNT in the cycle after the out_last transfer.
REQ-032 SHALL ignore rx_valid bytes arriving during CHECK or DRAIN, with drop_cnt incremented and saturating at 255.
REQ-033 SHALL not process rx_valid in cycle N+1 (CHECK) as a new byte.
REQ-034 CR, LF and trailing bytes after the checksum SHALL be ignored by HUNT.
REQ-035 Only the state visible between sentences SHALL be registered; all outputs SHALL be registered.

Reset
REQ-036 While rst is high at a sclk edge, SHALL enter HUNT.
REQ-037 On reset, SHALL clear len, the XOR and the received checksum.
REQ-038 On reset, SHALL set out_valid, out_last, frame_ok and frame_err to 0.
REQ-039 On reset, SHALL set frame_len to 0, err_code to NONE, drop_cnt to 0 and out_data to 0x00.
REQ-040 Reset mid-sentence or mid-DRAIN SHALL abandon the frame with no frame_err; buffer contents need not be cleared.

Structure
REQ-041 roversPackage SHALL hold nmea_err_t (NONE=0, BAD_CKSUM=1, OVERFLOW=2, BAD_CHAR=3).
REQ-042 roversPackage SHALL hold the constants NMEA_START=0x24 and NMEA_CKSEP=0x2A, plus the state enum type.
REQ-043 The payload buffer SHALL be one sub-module, nmea_sentence_buf: a MAX_PAYLOAD x 8 simple dual-port RAM with a registered read.
REQ-044 Hex decode SHALL be a function in roversPackage, not a module.

Verification
REQ-045 Send "$AB*03" -> frame_ok in cycle N+1 with frame_len=2; then out "A","B" with out_last on "B" and out_ready held high.
REQ-046 Send "$AB*04" -> frame_err with err_code=BAD_CKSUM; no out_valid ever.
REQ-047 Send "$" followed by 81 'A' bytes -> frame_err OVERFLOW on byte 81; a following "$A*41" -> frame_ok with frame_len=1.
REQ-048 Send "$AB*03"; hold out_ready low for 10 cycles, then toggle it every other cycle -> data stable while stalled, exactly 2 transfers; 3 rx bytes injected during DRAIN -> drop_cnt=3.
REQ-049 Send "$AB$CD*07" -> frame_ok with payload "CD"; send "$A\x01" -> frame_err BAD_CHAR; send "$AB*0g" -> frame_err BAD_CHAR.
REQ-050 Assert rst during DRAIN of "$AB*03" -> out_valid low in the next cycle, state HUNT, drop_cnt=0, no frame_err.
